// File: rtl/uart_rx_fifo_if.sv
// Host-side register interface of the UART receiver:
// FIFO head, occupancy, sticky status and the pop/clear strobes.
interface uart_rx_fifo_if #(
    parameter int FIFO_DEPTH_LOG2 = 3
);
    logic [7:0]               dataOut;
    logic                     parityError;
    logic                     framingError;
    logic                     dataValid;
    logic [FIFO_DEPTH_LOG2:0] fifoCount;
    logic                     receiveReq;
    logic                     clearFlags;
    logic                     overflow;
    logic                     rxBreak;

    modport master (
        output dataOut, parityError, framingError, dataValid,
        output fifoCount, overflow, rxBreak,
        input  receiveReq, clearFlags
    );

    modport slave (
        input  dataOut, parityError, framingError, dataValid,
        input  fifoCount, overflow, rxBreak,
        output receiveReq, clearFlags
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with majority-vote bit recovery,
// error/break detection and a first-word-fall-through receive FIFO.
module uart_rx_fifo #(
    parameter int CLOCK_DIVISOR_WIDTH = 24,
    parameter int OVERSAMPLE          = 16,
    parameter int FIFO_DEPTH_LOG2     = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rx,
    input  logic [1:0]                     dataBits,
    input  logic                           hasParity,
    input  logic [1:0]                     parityMode,
    input  logic                           extraStopBit,
    input  logic [CLOCK_DIVISOR_WIDTH-1:0] clockDivisor,
    uart_rx_fifo_if.master                 host
);
    localparam int SW    = $clog2(OVERSAMPLE);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;
    localparam logic [SW-1:0] S_A = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_B = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_D = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_E = SW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP1, STOP2, BRKWAIT
    } state_e;

    state_e state_q, state_d;

    logic [1:0] sync_q, vld_q;
    logic       prev_q;
    logic       rxs, start_edge;

    logic [1:0]                     db_q, pm_q;
    logic                           hp_q, es_q;
    logic [CLOCK_DIVISOR_WIDTH-1:0] div_q, cnt_q;
    logic [SW-1:0]                  s_q;
    logic                           tick, decide, bound;

    logic [1:0] smp_q;
    logic       vote;
    logic [7:0] sh_q, data_al;
    logic [3:0] bitn_q, nbits;
    logic       par_q, pbit_q, fe_q;
    logic       brk_cond, pe, fe_fin, push, brk_set;

    logic [9:0]                 mem_q [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_q, rd_q;
    logic [CW-1:0]              cnt_fq, cnt_fd;
    logic                       full, empty, pop, wr_en, ovf_set;
    logic                       ovf_q, ovf_d, brk_q, brk_d;
    logic [9:0]                 head;

    // vld_q masks the preset synchroniser value so a line held
    // low across reset release is never seen as a falling edge
    assign rxs        = sync_q[1];
    assign start_edge = (state_q == IDLE) && vld_q[1] && prev_q && !rxs;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
            vld_q  <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], rx};
            vld_q  <= {vld_q[0], 1'b1};
            prev_q <= rxs & vld_q[1];
        end
    end

    assign tick   = (state_q != IDLE) && (cnt_q == div_q);
    assign decide = tick && (s_q == S_D);
    assign bound  = tick && (s_q == S_E);

    always_ff @(posedge clk) begin
        if (rst || state_q == IDLE) begin
            cnt_q <= '0;
            s_q   <= '0;
        end else if (cnt_q == div_q) begin
            cnt_q <= '0;
            s_q   <= (s_q == S_E) ? '0 : s_q + SW'(1);
        end else begin
            cnt_q <= cnt_q + CLOCK_DIVISOR_WIDTH'(1);
        end
    end

    assign vote = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);
    assign nbits    = {2'b00, db_q} + 4'd5;
    assign data_al  = sh_q >> (3'd3 - {1'b0, db_q});
    assign brk_cond = (sh_q == 8'h00) && !(hp_q && pbit_q) && !vote;

    always_comb begin
        pe = 1'b0;
        case (pm_q)
            2'b10:   pe = par_q ^ pbit_q;
            2'b01:   pe = ~(par_q ^ pbit_q);
            2'b00:   pe = pbit_q;
            default: pe = ~pbit_q;
        endcase
        pe = pe & hp_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_edge) state_d = START;
            START:   if (decide && vote) state_d = IDLE;
                     else if (bound) state_d = DATA;
            DATA:    if (bound && bitn_q == nbits)
                         state_d = hp_q ? PARITY : STOP1;
            PARITY:  if (bound) state_d = STOP1;
            STOP1:   if (decide && brk_cond) state_d = BRKWAIT;
                     else if (decide && !es_q) state_d = IDLE;
                     else if (bound) state_d = STOP2;
            STOP2:   if (decide) state_d = IDLE;
            BRKWAIT: if (rxs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        push    = 1'b0;
        brk_set = 1'b0;
        fe_fin  = fe_q | ~vote;
        if (decide) begin
            case (state_q)
                STOP1: begin
                    brk_set = brk_cond;
                    push    = !brk_cond && !es_q;
                end
                STOP2:   push = 1'b1;
                default: push = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db_q   <= '0;
            hp_q   <= 1'b0;
            pm_q   <= '0;
            es_q   <= 1'b0;
            div_q  <= '0;
            smp_q  <= '0;
            sh_q   <= '0;
            bitn_q <= '0;
            par_q  <= 1'b0;
            pbit_q <= 1'b0;
            fe_q   <= 1'b0;
        end else begin
            if (start_edge) begin
                db_q   <= dataBits;
                hp_q   <= hasParity;
                pm_q   <= parityMode;
                es_q   <= extraStopBit;
                div_q  <= clockDivisor;
                sh_q   <= '0;
                bitn_q <= '0;
                par_q  <= 1'b0;
                pbit_q <= 1'b0;
                fe_q   <= 1'b0;
            end
            if (tick && s_q == S_A) smp_q[0] <= rxs;
            if (tick && s_q == S_B) smp_q[1] <= rxs;
            if (decide) begin
                case (state_q)
                    DATA: begin
                        sh_q   <= {vote, sh_q[7:1]};
                        bitn_q <= bitn_q + 4'd1;
                        par_q  <= par_q ^ vote;
                    end
                    PARITY:  pbit_q <= vote;
                    STOP1:   fe_q   <= ~vote;
                    default: ;
                endcase
            end
        end
    end

    // a full FIFO still accepts a frame when the head leaves the same cycle
    assign full    = (cnt_fq == CW'(DEPTH));
    assign empty   = (cnt_fq == '0);
    assign pop     = host.receiveReq && !empty;
    assign wr_en   = push && (!full || pop);
    assign ovf_set = push && full && !pop;

    always_comb begin
        cnt_fd = cnt_fq;
        if (wr_en && !pop) cnt_fd = cnt_fq + CW'(1);
        else if (!wr_en && pop) cnt_fd = cnt_fq - CW'(1);
    end

    assign ovf_d = ovf_set | (ovf_q & ~host.clearFlags);
    assign brk_d = brk_set | (brk_q & ~host.clearFlags);

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q] <= {fe_fin, pe, data_al};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_fq <= '0;
            ovf_q  <= 1'b0;
            brk_q  <= 1'b0;
        end else begin
            if (wr_en) wr_q <= wr_q + FIFO_DEPTH_LOG2'(1);
            if (pop)   rd_q <= rd_q + FIFO_DEPTH_LOG2'(1);
            cnt_fq <= cnt_fd;
            ovf_q  <= ovf_d;
            brk_q  <= brk_d;
        end
    end

    assign head              = empty ? 10'd0 : mem_q[rd_q];
    assign host.dataOut      = head[7:0];
    assign host.parityError  = head[8];
    assign host.framingError = head[9];
    assign host.dataValid    = !empty;
    assign host.fifoCount    = cnt_fq;
    assign host.overflow     = ovf_q;
    assign host.rxBreak      = brk_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: frames are bit-banged on rx
// and the FIFO head/status is compared against hand-computed values.
module tb_uart_rx_fifo;
    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic [1:0]  dataBits;
    logic        hasParity;
    logic [1:0]  parityMode;
    logic        extraStopBit;
    logic [23:0] clockDivisor;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.FIFO_DEPTH_LOG2(3)) host ();

    uart_rx_fifo #(
        .CLOCK_DIVISOR_WIDTH(24),
        .OVERSAMPLE(16),
        .FIFO_DEPTH_LOG2(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .dataBits(dataBits),
        .hasParity(hasParity),
        .parityMode(parityMode),
        .extraStopBit(extraStopBit),
        .clockDivisor(clockDivisor),
        .host(host)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // pop_at >= 0 pulses receiveReq on that cycle of the frame
    task automatic send(input logic [7:0] d, input int nb, input bit pen,
                        input bit pb, input bit s1, input bit two,
                        input bit s2, input int pop_at);
        logic [11:0] bits;
        int n;
        int len;
        int c;
        len  = 16 * (int'(clockDivisor) + 1);
        bits = '0;
        n    = 1;
        for (int i = 0; i < nb; i++) begin
            bits[n] = d[i];
            n++;
        end
        if (pen) begin
            bits[n] = pb;
            n++;
        end
        bits[n] = s1;
        n++;
        if (two) begin
            bits[n] = s2;
            n++;
        end
        c = 0;
        for (int b = 0; b < n; b++) begin
            for (int k = 0; k < len; k++) begin
                rx = bits[b];
                if (pop_at >= 0) host.receiveReq = (c == pop_at);
                @(negedge clk);
                c++;
            end
        end
        rx = 1'b1;
        host.receiveReq = 1'b0;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic pop1();
        host.receiveReq = 1'b1;
        @(negedge clk);
        host.receiveReq = 1'b0;
    endtask

    task automatic clr();
        host.clearFlags = 1'b1;
        @(negedge clk);
        host.clearFlags = 1'b0;
    endtask

    task automatic chk_empty(input string tag);
        check({tag, ".valid"}, 32'(host.dataValid), 32'd0);
        check({tag, ".count"}, 32'(host.fifoCount), 32'd0);
        check({tag, ".data"}, 32'(host.dataOut), 32'd0);
        check({tag, ".pe"}, 32'(host.parityError), 32'd0);
        check({tag, ".fe"}, 32'(host.framingError), 32'd0);
        check({tag, ".ovf"}, 32'(host.overflow), 32'd0);
        check({tag, ".brk"}, 32'(host.rxBreak), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        rx = 1'b1;
        dataBits = 2'd3;
        hasParity = 1'b0;
        parityMode = 2'b10;
        extraStopBit = 1'b0;
        clockDivisor = 24'd0;
        host.receiveReq = 1'b0;
        host.clearFlags = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        idle(10);
        chk_empty("reset");

        send(8'hA5, 8, 0, 0, 1, 0, 0, -1);
        check("a5.valid", 32'(host.dataValid), 32'd1);
        check("a5.data", 32'(host.dataOut), 32'hA5);
        check("a5.pe", 32'(host.parityError), 32'd0);
        check("a5.fe", 32'(host.framingError), 32'd0);
        check("a5.count", 32'(host.fifoCount), 32'd1);
        pop1();
        check("a5.popcnt", 32'(host.fifoCount), 32'd0);
        check("a5.popvld", 32'(host.dataValid), 32'd0);

        dataBits = 2'd2;
        hasParity = 1'b1;
        send(8'h41, 7, 1, 1, 1, 0, 0, -1);
        send(8'h41, 7, 1, 0, 1, 0, 0, -1);
        idle(5);
        check("7e1.count", 32'(host.fifoCount), 32'd2);
        check("7e1.pe1", 32'(host.parityError), 32'd1);
        check("7e1.d1", 32'(host.dataOut), 32'h41);
        pop1();
        check("7e1.pe2", 32'(host.parityError), 32'd0);
        check("7e1.d2", 32'(host.dataOut), 32'h41);
        pop1();
        dataBits = 2'd3;
        hasParity = 1'b0;

        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(40);
        check("glitch.count", 32'(host.fifoCount), 32'd0);
        check("glitch.brk", 32'(host.rxBreak), 32'd0);
        send(8'h3C, 8, 0, 0, 1, 0, 0, -1);
        check("post_glitch.data", 32'(host.dataOut), 32'h3C);
        check("post_glitch.count", 32'(host.fifoCount), 32'd1);
        pop1();

        for (int i = 0; i < 9; i++) send(8'(i), 8, 0, 0, 1, 0, 0, -1);
        idle(5);
        check("ovf.count", 32'(host.fifoCount), 32'd8);
        check("ovf.flag", 32'(host.overflow), 32'd1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ovf.pop%0d", i), 32'(host.dataOut), 32'(i));
            pop1();
        end
        check("ovf.empty", 32'(host.dataValid), 32'd0);
        clr();
        check("ovf.clr", 32'(host.overflow), 32'd0);

        rx = 1'b0;
        repeat (192) @(negedge clk);
        idle(20);
        check("brk.flag", 32'(host.rxBreak), 32'd1);
        check("brk.count", 32'(host.fifoCount), 32'd0);
        clr();
        check("brk.clr", 32'(host.rxBreak), 32'd0);
        send(8'h5A, 8, 0, 0, 1, 0, 0, -1);
        check("5a.data", 32'(host.dataOut), 32'h5A);
        pop1();

        for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), 8, 0, 0, 1, 0, 0, -1);
        check("full.count", 32'(host.fifoCount), 32'd8);
        // final-stop decision of an 8N1 frame at divisor 0 is cycle 156
        send(8'h18, 8, 0, 0, 1, 0, 0, 156);
        idle(5);
        check("pp.count", 32'(host.fifoCount), 32'd8);
        check("pp.ovf", 32'(host.overflow), 32'd0);
        for (int i = 1; i < 9; i++) begin
            check($sformatf("pp.pop%0d", i), 32'(host.dataOut),
                  32'h10 + 32'(i));
            pop1();
        end
        check("pp.empty", 32'(host.fifoCount), 32'd0);

        dataBits = 2'd0;
        extraStopBit = 1'b1;
        send(8'h15, 5, 0, 0, 1, 1, 0, -1);
        idle(5);
        check("5n2.count", 32'(host.fifoCount), 32'd1);
        check("5n2.fe", 32'(host.framingError), 32'd1);
        check("5n2.pe", 32'(host.parityError), 32'd0);
        check("5n2.data", 32'(host.dataOut), 32'h15);

        dataBits = 2'd3;
        extraStopBit = 1'b0;
        clockDivisor = 24'd1;
        rx = 1'b0;
        repeat (50) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        idle(400);
        chk_empty("rst_mid");

        send(8'hC3, 8, 0, 0, 1, 0, 0, -1);
        idle(5);
        check("c3.count", 32'(host.fifoCount), 32'd1);
        check("c3.data", 32'(host.dataOut), 32'hC3);
        check("c3.fe", 32'(host.framingError), 32'd0);
        check("c3.pe", 32'(host.parityError), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
